uart_rx_frontend: RTL and testbench



---
 rtl/uart_rx_frontend.sv | 157 +++++++++++++++
 tb/tb_uart_rx_frontend.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frontend.sv
// 8N1 serial receive front end: 2-flop synchronizer, 3-sample mid-bit majority vote,
// framing-error detection and a stretched rx_valid strobe for an edge-clocked consumer.
module uart_rx_frontend #(
    parameter int CLKS_PER_BIT = 868,
    parameter int VALID_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);
    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int VW = $clog2(VALID_CYCLES + 1);
    localparam logic [CW-1:0] CNT_SA   = CW'(H - 1);
    localparam logic [CW-1:0] CNT_SB   = CW'(H);
    localparam logic [CW-1:0] CNT_VOTE = CW'(H + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_e;

    state_e          state_q, state_d;
    logic            rx_meta_q, rx_s_q;
    logic            samp_a_q, samp_b_q;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      data_q, data_d;
    logic            ferr_q, ferr_d;
    logic            arm_q, arm_d;
    logic            valid_q;
    logic [VW-1:0]   vcnt_q;
    logic            vote, at_vote, at_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // First two vote samples are registered; the third is the live rx_s at the vote edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp_a_q <= 1'b1;
            samp_b_q <= 1'b1;
        end else begin
            if (cnt_q == CNT_SA) samp_a_q <= rx_s_q;
            if (cnt_q == CNT_SB) samp_b_q <= rx_s_q;
        end
    end

    assign vote    = (samp_a_q & samp_b_q) | (samp_a_q & rx_s_q) | (samp_b_q & rx_s_q);
    assign at_vote = (cnt_q == CNT_VOTE);
    assign at_last = (cnt_q == CNT_LAST);
    assign cnt_inc = at_last ? '0 : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        ferr_d  = 1'b0;
        arm_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = START;
            end
            START: begin
                cnt_d = cnt_inc;
                if (at_vote && vote) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (at_last) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                cnt_d = cnt_inc;
                if (at_vote) shreg_d = {vote, shreg_q[7:1]};
                if (at_last) begin
                    if (idx_q == 3'd7) state_d = STOP;
                    else               idx_d   = idx_q + 1'b1;
                end
            end
            STOP: begin
                cnt_d = cnt_inc;
                if (at_vote) begin
                    cnt_d = '0;
                    if (vote) begin
                        data_d  = shreg_q;
                        arm_d   = 1'b1;
                        // A short stop bit may already carry the next start edge.
                        state_d = rx_s_q ? IDLE : START;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            ferr_q  <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            ferr_q  <= ferr_d;
            arm_q   <= arm_d;
        end
    end

    // Pulse stretcher: re-arming restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            vcnt_q  <= '0;
        end else if (arm_q) begin
            valid_q <= 1'b1;
            vcnt_q  <= VW'(VALID_CYCLES - 1);
        end else if (vcnt_q != '0) begin
            vcnt_q  <= vcnt_q - 1'b1;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign rx_busy   = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend: a line-level decoding model checked every cycle,
// plus literal expectations for each scenario.
module tb_uart_rx_frontend;
    localparam int N    = 16;
    localparam int H    = N / 2;
    localparam int V    = 4;
    localparam int MAXC = 4096;

    logic       clk, reset, rx;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, rx_busy;

    uart_rx_frontend #(.CLKS_PER_BIT(N), .VALID_CYCLES(V)) dut (
        .clk(clk), .reset(reset), .rx(rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .rx_busy(rx_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit         line_h   [MAXC];
    logic [7:0] dut_data [MAXC];
    logic       dut_valid[MAXC];
    logic       dut_busy [MAXC];
    logic [7:0] got_q[$];
    int         nvalid = 0;
    int         nferr  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Line as seen through the two-flop synchronizer at edge t.
    function automatic bit rxs(int t);
        if (t < 3 || t - 2 >= MAXC) return 1'b1;
        return line_h[t-2];
    endfunction

    function automatic bit vote_at(int p);
        int s;
        s = int'(line_h[p]) + int'(line_h[p+1]) + int'(line_h[p+2]);
        return s >= 2;
    endfunction

    // Model: frame decode from the recorded line using the bit-timing rules.
    int         m_mode = 0;  // 0 idle, 1 in frame, 2 waiting for line high
    int         m_e0   = 0;
    logic [7:0] m_data = 8'h00;
    int         m_vfrom = 0, m_vto = -1, m_ferr_at = -1;

    initial begin
        int         r;
        logic [7:0] b;
        logic       prev_v;
        logic [7:0] prev_d;
        prev_v = 1'b0;
        prev_d = 8'h00;
        forever begin
            @(posedge clk);
            cyc++;
            if (cyc < MAXC) line_h[cyc] = reset ? 1'b1 : rx;
            if (reset) begin
                m_mode = 0; m_data = 8'h00; m_vto = -1; m_ferr_at = -1;
            end else if (m_mode == 0) begin
                if (!rxs(cyc)) begin m_e0 = cyc - 2; m_mode = 1; end
            end else if (m_mode == 1) begin
                r = cyc - m_e0;
                if (r == H + 4 && vote_at(m_e0 + H)) begin
                    m_mode = 0;
                end else if (r == 9*N + H + 4) begin
                    if (vote_at(m_e0 + 9*N + H)) begin
                        for (int k = 0; k < 8; k++) b[k] = vote_at(m_e0 + (k+1)*N + H);
                        m_data  = b;
                        m_vfrom = cyc + 1;
                        m_vto   = cyc + V;
                        if (!rxs(cyc)) begin m_e0 = cyc - 2; m_mode = 1; end
                        else m_mode = 0;
                    end else begin
                        m_ferr_at = cyc;
                        m_mode    = 2;
                    end
                end
            end else begin
                if (rxs(cyc)) m_mode = 0;
            end
            #1;
            chk("rx_data",   32'(rx_data),   32'(m_data));
            chk("rx_valid",  32'(rx_valid),  32'(cyc >= m_vfrom && cyc <= m_vto));
            chk("frame_err", 32'(frame_err), 32'(cyc == m_ferr_at));
            chk("rx_busy",   32'(rx_busy),   32'(m_mode != 0));
            if (rx_valid && !prev_v) begin
                chk("data_stable", 32'(rx_data), 32'(prev_d));
                got_q.push_back(rx_data);
                nvalid++;
            end
            if (frame_err) nferr++;
            if (cyc < MAXC) begin
                dut_data[cyc]  = rx_data;
                dut_valid[cyc] = rx_valid;
                dut_busy[cyc]  = rx_busy;
            end
            prev_v = rx_valid;
            prev_d = rx_data;
        end
    end

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    int last_e0;

    task automatic send(input logic [7:0] b, input int stop_len, input logic stop_v, input int spike_bit);
        last_e0 = cyc + 1;
        drive(1'b0, N);
        for (int i = 0; i < 8; i++) begin
            if (i == spike_bit) begin
                drive(b[i], H + 1);
                drive(~b[i], 1);
                drive(b[i], N - H - 2);
            end else begin
                drive(b[i], N);
            end
        end
        drive(stop_v, stop_len);
    endtask

    initial begin
        int         s, nv0, nf0, mark;
        logic [7:0] exp_b2b[5];
        exp_b2b = '{8'h72, 8'h34, 8'h12, 8'h10, 8'h00};
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_data",  32'(rx_data),   32'h0);
        chk("reset_valid", 32'(rx_valid),  32'h0);
        chk("reset_ferr",  32'(frame_err), 32'h0);
        chk("reset_busy",  32'(rx_busy),   32'h0);
        reset = 1'b0;
        drive(1'b1, 20);

        // Single byte with pinned timing
        send(8'h77, N, 1'b1, -1);
        drive(1'b1, 30);
        chk("b1_data_pre",   32'(dut_data[last_e0 + 9*N + H + 3]),  32'h00);
        chk("b1_data_upd",   32'(dut_data[last_e0 + 9*N + H + 4]),  32'h77);
        chk("b1_valid_pre",  32'(dut_valid[last_e0 + 9*N + H + 4]), 32'h0);
        chk("b1_valid_rise", 32'(dut_valid[last_e0 + 9*N + H + 5]), 32'h1);
        chk("b1_valid_last", 32'(dut_valid[last_e0 + 9*N + H + 4 + V]), 32'h1);
        chk("b1_valid_fall", 32'(dut_valid[last_e0 + 9*N + H + 5 + V]), 32'h0);
        s = 0;
        for (int i = last_e0; i <= last_e0 + 9*N + H + 20; i++) s += int'(dut_valid[i]);
        chk("b1_valid_len", 32'(s), 32'(V));
        chk("b1_no_ferr", 32'(nferr), 32'h0);

        // Back-to-back with minimal stop bits
        got_q.delete();
        foreach (exp_b2b[i]) send(exp_b2b[i], H + 2, 1'b1, -1);
        drive(1'b1, 40);
        chk("b2b_count", 32'(got_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) chk("b2b_byte", 32'(got_q[i]), 32'(exp_b2b[i]));

        // Framing error, stuck-low line, recovery
        nv0 = nvalid;
        nf0 = nferr;
        send(8'hA5, N + 40, 1'b0, -1);
        mark = cyc + 1;
        drive(1'b1, 20);
        chk("fe_pulses",    32'(nferr - nf0),  32'd1);
        chk("fe_no_valid",  32'(nvalid - nv0), 32'd0);
        chk("fe_busy_hold", 32'(dut_busy[mark + 1]), 32'h1);
        chk("fe_busy_drop", 32'(dut_busy[mark + 2]), 32'h0);
        send(8'h5A, N, 1'b1, -1);
        drive(1'b1, 30);
        chk("fe_recover", 32'(got_q[$]), 32'h5A);

        // False start
        nv0 = nvalid;
        nf0 = nferr;
        mark = cyc + 1;
        drive(1'b0, 3);
        drive(1'b1, 30);
        chk("fs_busy_start", 32'(dut_busy[mark + H + 3]), 32'h1);
        chk("fs_busy_abort", 32'(dut_busy[mark + H + 4]), 32'h0);
        chk("fs_no_valid",   32'(nvalid - nv0), 32'd0);
        chk("fs_no_ferr",    32'(nferr - nf0),  32'd0);
        send(8'h00, N, 1'b1, -1);
        drive(1'b1, 30);
        chk("fs_next_byte", 32'(got_q[$]), 32'h00);

        // Single-cycle spike inside the vote window of data bit 3
        send(8'hFF, N, 1'b1, 3);
        drive(1'b1, 30);
        chk("vote_byte", 32'(got_q[$]), 32'hFF);

        // Reset during data bit 4 of 0x3C; the sender abandons the frame
        nv0 = nvalid;
        nf0 = nferr;
        drive(1'b0, N);
        for (int i = 0; i < 4; i++) drive(1'(8'h3C >> i), N);
        drive(1'b1, 4);
        reset = 1'b1;
        #1;
        chk("rst_data",  32'(rx_data),   32'h0);
        chk("rst_valid", 32'(rx_valid),  32'h0);
        chk("rst_ferr",  32'(frame_err), 32'h0);
        chk("rst_busy",  32'(rx_busy),   32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 12 * N);
        chk("rst_no_valid", 32'(nvalid - nv0), 32'd0);
        chk("rst_no_ferr",  32'(nferr - nf0),  32'd0);
        send(8'hC3, N, 1'b1, -1);
        drive(1'b1, 30);
        chk("rst_next_byte", 32'(got_q[$]), 32'hC3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
